segre_mem_stage: RTL and testbench
==================================

# segre_mem_stage

Memory stage of the Segre pipeline. It registers the EX→MEM bundle (ALU result/address, store data, memop controls, register-file write info) and issues byte-enabled requests on the data-memory req/gnt/rvalid interface. It aligns and sign-extends load data, then presents the write-back bundle and the MEM-stage bypass value. A three-state FSM tracks outstanding accesses and self-stalls the stage, asserting `mem_busy_o` to ctrl until the access completes.

## Interface
Parameters (from `segre_pkg`)
- WORD_SIZE, 32, data width
- ADDR_SIZE, 32, address width
- REG_SIZE, 5, register index width

Ports
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  synchronous, active-high reset
- valid_ex_i  in  1  EX bundle valid
- alu_res_i  in  WORD_SIZE  ALU result; the effective address for memops
- rf_we_i / rf_waddr_i  in  1 / REG_SIZE  register-file write enable and index
- rf_st_data_i  in  WORD_SIZE  store data, already bypassed
- memop_type_i  in  memop_data_type_e  BYTE / HALF / WORD
- memop_rd_i / memop_wr_i / memop_sign_ext_i  in  1 each  load, store, sign-extend
- finish_test_i  in  1  end-of-test marker
- block_mem_i  in  1  hold the input register (downstream stall)
- inject_nops_i  in  1  load a bubble into the input register
- dmem_req_o / dmem_we_o  out  1 / 1  request strobe and write flag
- dmem_addr_o  out  ADDR_SIZE  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  WORD_SIZE  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i / dmem_rdata_i  in  1 / WORD_SIZE  load response
- rf_we_o / rf_waddr_o / rf_wdata_o  out  1 / REG_SIZE / WORD_SIZE  write-back bundle
- valid_mem_o  out  1  write-back bundle valid this cycle
- op_res_stage_mem_o  out  WORD_SIZE  bypass value, equal to the ALU result of the held instruction
- mem_busy_o  out  1  access in flight; ctrl must block IF/ID/EX
- misaligned_o  out  1  one-cycle flag for a misaligned memop
- finish_test_o  out  1  registered finish marker, gated by valid_mem_o

## Operation
- Input register captures the EX bundle each cycle unless a hold or bubble applies.
  - `block_mem_i` = 1 or `mem_busy_o` = 1: hold.
  - `inject_nops_i`: clear valid, rf_we, memop_rd and memop_wr.
  - Priority: reset > hold > inject > load.
- FSM `mem_state_e`: MEM_IDLE, MEM_REQ, MEM_WAIT.
  - MEM_IDLE: if the held instruction is valid, rd|wr is set, and the access is aligned, raise req combinationally this cycle.
    - gnt=1 on a store → complete; stay IDLE.
    - gnt=1 on a load → MEM_WAIT.
    - gnt=0 → MEM_REQ.
  - MEM_REQ: keep req/addr/be/wdata/we stable until gnt. On gnt, a store completes (→ IDLE) and a load goes to MEM_WAIT.
  - MEM_WAIT: req=0. On rvalid, complete and return to IDLE. rvalid outside MEM_WAIT is ignored.
- mem_busy_o = 1 for a valid memop in any cycle it does not complete.
- valid_mem_o:
  - Non-memops: equals held valid.
  - Memops: asserted only in the completion cycle.
- Byte enables and store data:
  - BYTE: be = 1<<addr[1:0]; wdata = {4{st[7:0]}}.
  - HALF: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{st[15:0]}}.
  - WORD: be = 4'b1111.
- Load alignment: select the byte or half by addr[1:0], then zero- or sign-extend per memop_sign_ext. rf_wdata_o = aligned rdata for loads, ALU result otherwise.
- Misalignment: HALF with addr[0]=1, or WORD with addr[1:0]≠0. Result: no request, misaligned_o=1 for one cycle, rf_we_o=0, valid_mem_o=1 (instruction retires as a nop).
- rf_we_o = held rf_we & valid_mem_o.

## Timing
- Reset: FSM→MEM_IDLE and all valid/we/rd/wr/finish cleared. Every output is 0, except the data buses, which are 0 because their select inputs are cleared.
- Reset mid-access abandons the access. A later stray rvalid is dropped because the FSM is in IDLE.
- Non-memop: instruction enters on edge N and is presented to WB throughout cycle N.
- Store, gnt same cycle: 0 stall cycles.
- Load, gnt in the req cycle and rvalid next cycle: 1 stall cycle; data presented in the rvalid cycle.
- Each cycle of gnt=0 or rvalid=0 adds one stall cycle.
- block_mem_i during MEM_WAIT: the FSM still advances on rvalid, and the load data is captured into a result holding register. valid_mem_o stays asserted until the first cycle with block_mem_i=0.

## Structure
- `segre_pkg` additions: `mem_state_e`; reuses the existing `memop_data_type_e`.
- Sub-module `segre_load_align` (combinational): inputs rdata, addr[1:0], type, sign_ext; output WORD_SIZE result. It is shared with the bench reference model.

## Test plan
- ADD result 0x1234, rf_we=1, x5 → one cycle later rf_wdata_o=0x1234, rf_waddr_o=5, valid_mem_o=1, no req.
- SB st=0x000000AB, addr 0x103, gnt same cycle → be=4'b1000, wdata=0xABABABAB, addr 0x100, mem_busy_o=0.
- LH signed, addr 0x202, gnt after 2 cycles, rdata 0x8001_0000 → rf_wdata_o=0xFFFF8001. mem_busy_o high for 3 cycles (2 gnt waits + 1 rvalid wait); req stable throughout.
- LW addr 0x206 → misaligned_o=1, no req, rf_we_o=0, valid_mem_o=1.
- LBU at addr 0x01, rdata 0xFF in byte 1, block_mem_i high for 3 cycles around rvalid → 0x000000FF held and delivered exactly once.
- rst_i asserted in MEM_WAIT, then stray rvalid → FSM IDLE, valid_mem_o=0, rf_we_o=0.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types, widths and small helpers for the Segre pipeline memory stage.
package segre_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;
    localparam int REG_SIZE  = 5;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_REQ  = 2'b01,
        MEM_WAIT = 2'b10
    } mem_state_e;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byte_enable(memop_data_type_e t, logic [1:0] a);
        logic [3:0] be;
        case (t)
            BYTE:    be = 4'b0001 << a;
            HALF:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Halves must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(memop_data_type_e t, logic [1:0] a);
        logic mis;
        case (t)
            BYTE:    mis = 1'b0;
            HALF:    mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/segre_mem_stage_if.sv
// Data-memory request/grant/response bus between the memory stage and memory.
// Handshake: a request is accepted in a cycle where req and gnt are both high;
// the stage keeps we/addr/be/wdata stable while req is high and gnt is low.
// A load answer arrives later as a single-cycle rvalid pulse with rdata.
interface segre_mem_stage_if;
    import segre_pkg::*;

    logic                 req;
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [3:0]           be;
    logic [WORD_SIZE-1:0] wdata;
    logic                 gnt;
    logic                 rvalid;
    logic [WORD_SIZE-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/segre_load_align.sv
// Picks the addressed byte or half out of a load word and zero/sign-extends it.
module segre_load_align
    import segre_pkg::*;
(
    input  logic [WORD_SIZE-1:0] rdata,
    input  logic [1:0]           addr,
    input  memop_data_type_e     memop_type,
    input  logic                 sign_ext,
    output logic [WORD_SIZE-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension to the full register width.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (memop_type)
            BYTE: result = sign_ext ? {{(WORD_SIZE-8){byte_sel[7]}}, byte_sel}
                                    : {{(WORD_SIZE-8){1'b0}}, byte_sel};
            HALF: result = sign_ext ? {{(WORD_SIZE-16){half_sel[15]}}, half_sel}
                                    : {{(WORD_SIZE-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/segre_mem_stage.sv
// Segre MEM stage: registers the EX bundle, drives the data-memory bus, aligns
// load data and presents the write-back bundle. Stalls itself while an access
// is in flight and holds a finished load result while write-back is blocked.
module segre_mem_stage
    import segre_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_ex_i,
    input  logic [WORD_SIZE-1:0] alu_res_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  rf_waddr_i,
    input  logic [WORD_SIZE-1:0] rf_st_data_i,
    input  memop_data_type_e     memop_type_i,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic                 memop_sign_ext_i,
    input  logic                 finish_test_i,
    input  logic                 block_mem_i,
    input  logic                 inject_nops_i,
    segre_mem_stage_if.master    dmem,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 valid_mem_o,
    output logic [WORD_SIZE-1:0] op_res_stage_mem_o,
    output logic                 mem_busy_o,
    output logic                 misaligned_o,
    output logic                 finish_test_o,
    output mem_state_e           mem_state_o
);

    logic                 valid_q;
    logic [WORD_SIZE-1:0] alu_res_q;
    logic                 rf_we_q;
    logic [REG_SIZE-1:0]  rf_waddr_q;
    logic [WORD_SIZE-1:0] st_data_q;
    memop_data_type_e     type_q;
    logic                 rd_q;
    logic                 wr_q;
    logic                 sext_q;
    logic                 finish_q;

    mem_state_e           state_q;
    mem_state_e           state_d;
    logic                 done_q;
    logic [WORD_SIZE-1:0] res_q;

    logic                 hold;
    logic                 is_memop;
    logic                 misaligned;
    logic                 access;
    logic                 req;
    logic                 complete;
    logic [WORD_SIZE-1:0] load_data;

    assign hold       = block_mem_i | mem_busy_o;
    assign is_memop   = valid_q & (rd_q | wr_q);
    assign misaligned = is_memop & is_misaligned(type_q, alu_res_q[1:0]);
    // done_q marks an access that already finished but could not retire yet;
    // it must not be issued again.
    assign access     = is_memop & ~misaligned & ~done_q;

    // Input register: reset > hold > bubble injection > load from EX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            alu_res_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            st_data_q  <= '0;
            type_q     <= BYTE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            sext_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else if (hold) begin
            valid_q    <= valid_q;
        end else if (inject_nops_i) begin
            valid_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            valid_q    <= valid_ex_i;
            alu_res_q  <= alu_res_i;
            rf_we_q    <= rf_we_i;
            rf_waddr_q <= rf_waddr_i;
            st_data_q  <= rf_st_data_i;
            type_q     <= memop_type_i;
            rd_q       <= memop_rd_i;
            wr_q       <= memop_wr_i;
            sext_q     <= memop_sign_ext_i;
            finish_q   <= finish_test_i;
        end
    end

    // Access FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= MEM_IDLE;
        else       state_q <= state_d;
    end

    // Next state, request strobe and completion of the held access.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        complete = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (dmem.gnt) begin
                        if (rd_q) state_d = MEM_WAIT;
                        else      complete = 1'b1;
                    end else begin
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (!access) begin
                    state_d = MEM_IDLE;
                end else begin
                    req = 1'b1;
                    if (dmem.gnt) begin
                        if (rd_q) begin
                            state_d = MEM_WAIT;
                        end else begin
                            complete = 1'b1;
                            state_d  = MEM_IDLE;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem.rvalid) begin
                    complete = 1'b1;
                    state_d  = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    segre_load_align u_load_align (
        .rdata      (dmem.rdata),
        .addr       (alu_res_q[1:0]),
        .memop_type (type_q),
        .sign_ext   (sext_q),
        .result     (load_data)
    );

    // Keep a finished access (and its load data) while write-back is blocked.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= block_mem_i & (done_q | complete);
            if (state_q == MEM_WAIT && dmem.rvalid) res_q <= load_data;
        end
    end

    assign mem_busy_o  = access & ~complete;
    assign valid_mem_o = (is_memop & ~misaligned) ? (complete | done_q) : valid_q;
    assign rf_we_o     = rf_we_q & valid_mem_o & ~misaligned;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = (valid_q & rd_q & ~misaligned) ? (done_q ? res_q : load_data)
                                                        : alu_res_q;
    assign op_res_stage_mem_o = alu_res_q;
    assign misaligned_o  = misaligned;
    assign finish_test_o = finish_q & valid_mem_o;
    assign mem_state_o   = state_q;

    assign dmem.req   = req;
    assign dmem.we    = req & wr_q;
    assign dmem.be    = req ? byte_enable(type_q, alu_res_q[1:0]) : 4'b0000;
    assign dmem.addr  = {alu_res_q[ADDR_SIZE-1:2], 2'b00};
    assign dmem.wdata = (type_q == BYTE) ? {4{st_data_q[7:0]}} :
                        (type_q == HALF) ? {2{st_data_q[15:0]}} : st_data_q;

endmodule

// File: tb/tb_segre_mem_stage.sv
// Directed bench for segre_mem_stage with a write-back scoreboard.
module tb_segre_mem_stage;
    import segre_pkg::*;

    logic                 clk_i;
    logic                 rst_i;
    logic                 valid_ex_i;
    logic [WORD_SIZE-1:0] alu_res_i;
    logic                 rf_we_i;
    logic [REG_SIZE-1:0]  rf_waddr_i;
    logic [WORD_SIZE-1:0] rf_st_data_i;
    memop_data_type_e     memop_type_i;
    logic                 memop_rd_i;
    logic                 memop_wr_i;
    logic                 memop_sign_ext_i;
    logic                 finish_test_i;
    logic                 block_mem_i;
    logic                 inject_nops_i;
    logic                 rf_we_o;
    logic [REG_SIZE-1:0]  rf_waddr_o;
    logic [WORD_SIZE-1:0] rf_wdata_o;
    logic                 valid_mem_o;
    logic [WORD_SIZE-1:0] op_res_stage_mem_o;
    logic                 mem_busy_o;
    logic                 misaligned_o;
    logic                 finish_test_o;
    mem_state_e           mem_state_o;

    segre_mem_stage_if dmem ();

    segre_mem_stage dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .valid_ex_i         (valid_ex_i),
        .alu_res_i          (alu_res_i),
        .rf_we_i            (rf_we_i),
        .rf_waddr_i         (rf_waddr_i),
        .rf_st_data_i       (rf_st_data_i),
        .memop_type_i       (memop_type_i),
        .memop_rd_i         (memop_rd_i),
        .memop_wr_i         (memop_wr_i),
        .memop_sign_ext_i   (memop_sign_ext_i),
        .finish_test_i      (finish_test_i),
        .block_mem_i        (block_mem_i),
        .inject_nops_i      (inject_nops_i),
        .dmem               (dmem.master),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o),
        .valid_mem_o        (valid_mem_o),
        .op_res_stage_mem_o (op_res_stage_mem_o),
        .mem_busy_o         (mem_busy_o),
        .misaligned_o       (misaligned_o),
        .finish_test_o      (finish_test_o),
        .mem_state_o        (mem_state_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;
    int          hs_base  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    // Clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input logic [31:0] alu, input logic we, input logic [4:0] wa,
                            input logic [31:0] st, input memop_data_type_e t,
                            input logic rd, input logic wr, input logic sx, input logic fin);
        valid_ex_i       = 1'b1;
        alu_res_i        = alu;
        rf_we_i          = we;
        rf_waddr_i       = wa;
        rf_st_data_i     = st;
        memop_type_i     = t;
        memop_rd_i       = rd;
        memop_wr_i       = wr;
        memop_sign_ext_i = sx;
        finish_test_i    = fin;
    endtask

    task automatic clear_ex();
        valid_ex_i       = 1'b0;
        alu_res_i        = '0;
        rf_we_i          = 1'b0;
        rf_waddr_i       = '0;
        rf_st_data_i     = '0;
        memop_type_i     = BYTE;
        memop_rd_i       = 1'b0;
        memop_wr_i       = 1'b0;
        memop_sign_ext_i = 1'b0;
        finish_test_i    = 1'b0;
    endtask

    // Mid-cycle sampling point, away from the rising edge.
    task automatic mid();
        @(negedge clk_i);
    endtask

    // Scoreboard pop for a retired write-back, handshake count, then next cycle.
    task automatic next();
        if (dmem.req && dmem.gnt) hs_cnt++;
        if (valid_mem_o && rf_we_o && !block_mem_i) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL wb_unexpected: observed %h, expected no write-back", rf_wdata_o);
            end
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check("wb_data", rf_wdata_o, exp_v);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i         = 1'b1;
        block_mem_i   = 1'b0;
        inject_nops_i = 1'b0;
        dmem.gnt      = 1'b0;
        dmem.rvalid   = 1'b0;
        dmem.rdata    = '0;
        clear_ex();
        repeat (2) @(posedge clk_i);
        #1;

        // Reset state
        mid();
        check("rst_valid", valid_mem_o, 0);
        check("rst_rf_we", rf_we_o, 0);
        check("rst_wdata", rf_wdata_o, 0);
        check("rst_waddr", rf_waddr_o, 0);
        check("rst_req", dmem.req, 0);
        check("rst_be", dmem.be, 0);
        check("rst_addr", dmem.addr, 0);
        check("rst_busy", mem_busy_o, 0);
        check("rst_mis", misaligned_o, 0);
        check("rst_fin", finish_test_o, 0);
        check("rst_state", mem_state_o, MEM_IDLE);
        next();
        rst_i = 1'b0;

        // ADD result 0x1234 to x5
        drive_ex(32'h1234, 1'b1, 5'd5, 32'h0, BYTE, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h1234);
        mid(); next();
        clear_ex();
        mid();
        check("add_valid", valid_mem_o, 1);
        check("add_wdata", rf_wdata_o, 32'h1234);
        check("add_waddr", rf_waddr_o, 5);
        check("add_we", rf_we_o, 1);
        check("add_bypass", op_res_stage_mem_o, 32'h1234);
        check("add_req", dmem.req, 0);
        next();

        // SB 0xAB at 0x103, granted at once
        drive_ex(32'h103, 1'b0, 5'd0, 32'h0000_00AB, BYTE, 1'b0, 1'b1, 1'b0, 1'b0);
        mid(); next();
        clear_ex();
        dmem.gnt = 1'b1;
        mid();
        check("sb_req", dmem.req, 1);
        check("sb_we", dmem.we, 1);
        check("sb_be", dmem.be, 4'b1000);
        check("sb_wdata", dmem.wdata, 32'hABAB_ABAB);
        check("sb_addr", dmem.addr, 32'h100);
        check("sb_busy", mem_busy_o, 0);
        check("sb_valid", valid_mem_o, 1);
        check("sb_rf_we", rf_we_o, 0);
        next();
        dmem.gnt = 1'b0;
        mid();
        check("sb_after_req", dmem.req, 0);
        check("sb_after_valid", valid_mem_o, 0);
        next();

        // SH 0x1234ABCD at 0x102, one cycle without grant
        drive_ex(32'h102, 1'b0, 5'd0, 32'h1234_ABCD, HALF, 1'b0, 1'b1, 1'b0, 1'b0);
        mid(); next();
        clear_ex();
        mid();
        check("sh_req0", dmem.req, 1);
        check("sh_be0", dmem.be, 4'b1100);
        check("sh_wdata0", dmem.wdata, 32'hABCD_ABCD);
        check("sh_busy0", mem_busy_o, 1);
        check("sh_valid0", valid_mem_o, 0);
        next();
        dmem.gnt = 1'b1;
        mid();
        check("sh_req1", dmem.req, 1);
        check("sh_be1", dmem.be, 4'b1100);
        check("sh_wdata1", dmem.wdata, 32'hABCD_ABCD);
        check("sh_busy1", mem_busy_o, 0);
        check("sh_valid1", valid_mem_o, 1);
        next();
        dmem.gnt = 1'b0;
        mid();
        check("sh_after_req", dmem.req, 0);
        next();

        // LH signed at 0x202, grant after two cycles, then rvalid
        drive_ex(32'h202, 1'b1, 5'd7, 32'h0, HALF, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(32'hFFFF_8001);
        mid(); next();
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            dmem.gnt = (i == 2);
            mid();
            check("lh_req", dmem.req, 1);
            check("lh_addr", dmem.addr, 32'h200);
            check("lh_be", dmem.be, 4'b1100);
            check("lh_we", dmem.we, 0);
            check("lh_busy", mem_busy_o, 1);
            check("lh_valid_wait", valid_mem_o, 0);
            next();
        end
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'h8001_0000;
        mid();
        check("lh_req_wait", dmem.req, 0);
        check("lh_busy_done", mem_busy_o, 0);
        check("lh_valid", valid_mem_o, 1);
        check("lh_waddr", rf_waddr_o, 7);
        next();
        dmem.rvalid = 1'b0;
        dmem.rdata  = '0;
        mid();
        check("lh_after_valid", valid_mem_o, 0);
        next();

        // LB signed at 0x3: grant at once, rvalid next cycle
        drive_ex(32'h3, 1'b1, 5'd9, 32'h0, BYTE, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(32'hFFFF_FF80);
        mid(); next();
        clear_ex();
        dmem.gnt = 1'b1;
        mid();
        check("lb_be", dmem.be, 4'b1000);
        check("lb_busy", mem_busy_o, 1);
        next();
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'h8012_3456;
        mid();
        check("lb_valid", valid_mem_o, 1);
        check("lb_waddr", rf_waddr_o, 9);
        next();
        dmem.rvalid = 1'b0;

        // LW at 0x206 is misaligned
        drive_ex(32'h206, 1'b1, 5'd3, 32'h0, WORD, 1'b1, 1'b0, 1'b0, 1'b0);
        mid(); next();
        clear_ex();
        mid();
        check("lw_mis", misaligned_o, 1);
        check("lw_req", dmem.req, 0);
        check("lw_rf_we", rf_we_o, 0);
        check("lw_valid", valid_mem_o, 1);
        check("lw_busy", mem_busy_o, 0);
        next();
        mid();
        check("lw_mis_pulse", misaligned_o, 0);
        next();

        // LBU at 0x01 with block_mem_i high around rvalid
        hs_base = hs_cnt;
        drive_ex(32'h1, 1'b1, 5'd4, 32'h0, BYTE, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h0000_00FF);
        mid(); next();
        clear_ex();
        dmem.gnt = 1'b1;
        mid();
        check("lbu_be", dmem.be, 4'b0010);
        next();
        dmem.gnt    = 1'b0;
        block_mem_i = 1'b1;
        mid();
        check("lbu_busy_wait", mem_busy_o, 1);
        check("lbu_valid_wait", valid_mem_o, 0);
        next();
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'h0000_FF00;
        mid();
        check("lbu_valid_rv", valid_mem_o, 1);
        check("lbu_data_rv", rf_wdata_o, 32'h0000_00FF);
        check("lbu_busy_rv", mem_busy_o, 0);
        next();
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'hDEAD_BEEF;
        mid();
        check("lbu_hold_valid", valid_mem_o, 1);
        check("lbu_hold_data", rf_wdata_o, 32'h0000_00FF);
        check("lbu_hold_req", dmem.req, 0);
        check("lbu_hold_state", mem_state_o, MEM_IDLE);
        next();
        block_mem_i = 1'b0;
        mid();
        check("lbu_rel_valid", valid_mem_o, 1);
        check("lbu_rel_req", dmem.req, 0);
        next();
        mid();
        check("lbu_after_valid", valid_mem_o, 0);
        check("lbu_handshakes", hs_cnt - hs_base, 1);
        next();

        // Reset while waiting for a load, then a stray rvalid
        drive_ex(32'h300, 1'b1, 5'd6, 32'h0, WORD, 1'b1, 1'b0, 1'b0, 1'b0);
        mid(); next();
        clear_ex();
        dmem.gnt = 1'b1;
        mid(); next();
        dmem.gnt = 1'b0;
        rst_i    = 1'b1;
        mid();
        check("rstw_state", mem_state_o, MEM_WAIT);
        check("rstw_busy", mem_busy_o, 1);
        next();
        rst_i       = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'h1111_1111;
        mid();
        check("rstw_state_idle", mem_state_o, MEM_IDLE);
        check("rstw_valid", valid_mem_o, 0);
        check("rstw_rf_we", rf_we_o, 0);
        check("rstw_req", dmem.req, 0);
        next();
        dmem.rvalid = 1'b0;

        // Bubble injection turns an ADD into a nop
        drive_ex(32'h55, 1'b1, 5'd2, 32'h0, BYTE, 1'b0, 1'b0, 1'b0, 1'b0);
        inject_nops_i = 1'b1;
        mid(); next();
        clear_ex();
        inject_nops_i = 1'b0;
        mid();
        check("inj_valid", valid_mem_o, 0);
        check("inj_rf_we", rf_we_o, 0);
        next();

        // End-of-test marker
        drive_ex(32'h0, 1'b0, 5'd0, 32'h0, BYTE, 1'b0, 1'b0, 1'b0, 1'b1);
        mid(); next();
        clear_ex();
        mid();
        check("fin_on", finish_test_o, 1);
        next();
        mid();
        check("fin_off", finish_test_o, 0);
        check("handshakes_total", hs_cnt, 6);
        check("scoreboard_empty", exp_q.size(), 0);
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
